// File: rtl/eth_tx_arbiter_pkg.sv
// eth_tx_arbiter_pkg: shared state encoding, byte type and requester slot
// constants for the GMII transmit arbiter and its sources.
package eth_tx_arbiter_pkg;

   // one-hot arbiter states
   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_GRANT = 4'b0010,
      S_XMIT  = 4'b0100,
      S_IFG   = 4'b1000
   } state_t;

   localparam int ETH_IFG_CYC = 12;

   typedef logic [7:0] byte_t;

   // fixed requester slots: ARP and ICMP form the high-priority class
   localparam int REQ_ARP  = 0;
   localparam int REQ_ICMP = 1;
   localparam int REQ_UDP1 = 2;
   localparam int REQ_UDP2 = 3;

endpackage

// File: rtl/eth_tx_arbiter_if.sv
// eth_tx_arbiter_if: frame sources <-> arbiter bundle (request, per-source
// txctl/txd, one-hot grant). master = source side, slave = arbiter side.
interface eth_tx_arbiter_if #(
   parameter int N_REQ = 4
);
   import eth_tx_arbiter_pkg::*;

   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   tx_ctl_in;
   logic [N_REQ*8-1:0] tx_d_in;
   logic [N_REQ-1:0]   gnt;

   modport master (output req, output tx_ctl_in, output tx_d_in, input gnt);
   modport slave  (input req, input tx_ctl_in, input tx_d_in, output gnt);

endinterface

// File: rtl/eth_tx_arbiter_rr_pick.sv
// eth_tx_arbiter_rr_pick: combinational selector. Lowest eligible
// high-priority index wins; otherwise the first eligible round-robin index at
// or after rr_ptr, wrapping.
module eth_tx_arbiter_rr_pick #(
   parameter int               N_REQ   = 4,
   parameter logic [N_REQ-1:0] HP_MASK = 4'b0011
) (
   input  logic [N_REQ-1:0]         eligible,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   output logic [$clog2(N_REQ)-1:0] sel,
   output logic                     valid
);
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0]   hp_req;
   logic [N_REQ-1:0]   rr_req;
   logic [N_REQ-1:0]   rr_rot;
   logic [2*N_REQ-1:0] rr_dbl;
   logic [IW-1:0]      hp_sel;
   int                 rot_sel;
   int                 wrap_sel;

   // rotate round-robin candidates so rr_ptr sits at bit 0, take lowest set bit, rotate back
   always_comb begin
      hp_req = eligible & HP_MASK;
      rr_req = eligible & ~HP_MASK;
      rr_dbl = {rr_req, rr_req};
      rr_rot = N_REQ'(rr_dbl >> rr_ptr);
      hp_sel = '0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (hp_req[i]) hp_sel = IW'(i);
      rot_sel = 0;
      for (int i = N_REQ - 1; i >= 0; i--)
         if (rr_rot[i]) rot_sel = i;
      wrap_sel = int'(rr_ptr) + rot_sel;
      if (wrap_sel >= N_REQ) wrap_sel = wrap_sel - N_REQ;
      valid = |eligible;
      sel   = (|hp_req) ? hp_sel : IW'(wrap_sel);
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-granular arbiter for the shared GMII transmit path.
// A granted frame is never cut or interleaved; IFG_CYC idle cycles follow
// every frame. Optional statistics outputs (frame_cnt, timeout_cnt) are built
// when ETH_TX_ARB_STATS_EN is defined.
module eth_tx_arbiter
   import eth_tx_arbiter_pkg::*;
#(
   parameter int               N_REQ    = 4,
   parameter int               IFG_CYC  = ETH_IFG_CYC,
   parameter int               START_TO = 64,
   parameter logic [N_REQ-1:0] HP_MASK  = N_REQ'((1 << REQ_ARP) | (1 << REQ_ICMP))
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         enable_mask,
   eth_tx_arbiter_if.slave          src,
   output logic                     gmii_eth_txctl,
   output byte_t                    gmii_eth_txd,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] owner
`ifdef ETH_TX_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]      frame_cnt,
   output logic [15:0]              timeout_cnt
`endif
);
   localparam int IW = $clog2(N_REQ);
   localparam int TW = $clog2(START_TO + 1);
   localparam int CW = $clog2(IFG_CYC + 1);

   state_t           state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]    owner_q, rr_ptr_q, sel;
   logic             sel_vld;
   logic [TW-1:0]    to_cnt_q;
   logic [CW-1:0]    ifg_cnt_q;
   logic             own_ctl, own_req, to_hit, ifg_done;
   logic             load_sel, frame_done;
   byte_t            own_d;
   logic             vld_p1;
   byte_t            txd_p1;

   function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] i);
      return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
   endfunction

   eth_tx_arbiter_rr_pick #(.N_REQ(N_REQ), .HP_MASK(HP_MASK)) u_pick (
      .eligible (src.req & enable_mask),
      .rr_ptr   (rr_ptr_q),
      .sel      (sel),
      .valid    (sel_vld)
   );

   assign own_ctl    = src.tx_ctl_in[owner_q];
   assign own_req    = src.req[owner_q];
   assign own_d      = src.tx_d_in[{owner_q, 3'b000} +: 8];
   assign to_hit     = (to_cnt_q == TW'(START_TO - 1));
   assign ifg_done   = (ifg_cnt_q == CW'(IFG_CYC - 1));
   assign load_sel   = (state_q == S_IDLE) && sel_vld;
   assign frame_done = (state_q == S_XMIT) && !own_ctl;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // next-state: grant on any eligible request, revoke on request drop or start timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (sel_vld) state_d = S_GRANT;
         S_GRANT: begin
            if (own_ctl)                  state_d = S_XMIT;
            else if (!own_req || to_hit)  state_d = S_IDLE;
         end
         S_XMIT:  if (!own_ctl)  state_d = S_IFG;
         S_IFG:   if (ifg_done)  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // grant decode: grant follows the selection, drops on frame end or revoke
   always_comb begin
      gnt_d = gnt_q;
      unique case (state_q)
         S_IDLE:  gnt_d = sel_vld ? (N_REQ'(1) << sel) : '0;
         S_GRANT: if (!own_ctl && (!own_req || to_hit)) gnt_d = '0;
         S_XMIT:  if (!own_ctl) gnt_d = '0;
         default: gnt_d = '0;
      endcase
   end

   // grant, owner, round-robin pointer, start-timeout and gap counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q     <= '0;
         owner_q   <= '0;
         rr_ptr_q  <= '0;
         to_cnt_q  <= '0;
         ifg_cnt_q <= '0;
      end else begin
         gnt_q <= gnt_d;
         if (load_sel) begin
            owner_q  <= sel;
            rr_ptr_q <= ptr_after(sel);
            to_cnt_q <= '0;
         end else if (state_q == S_GRANT && !to_hit) begin
            to_cnt_q <= to_cnt_q + 1'b1;
         end
         if (frame_done)
            ifg_cnt_q <= '0;
         else if (state_q == S_IFG && ifg_cnt_q != CW'(IFG_CYC))
            ifg_cnt_q <= ifg_cnt_q + 1'b1;
      end
   end

   // ---- stage p1: owner's txctl/txd registered; forced idle outside GRANT/XMIT ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         txd_p1 <= '0;
      end else if (state_q == S_GRANT || state_q == S_XMIT) begin
         vld_p1 <= own_ctl;
         txd_p1 <= own_d;
      end else begin
         vld_p1 <= 1'b0;
         txd_p1 <= '0;
      end
   end

   assign src.gnt        = gnt_q;
   assign gmii_eth_txctl = vld_p1;
   assign gmii_eth_txd   = txd_p1;
   assign busy           = (state_q != S_IDLE);
   assign owner          = owner_q;

`ifdef ETH_TX_ARB_STATS_EN
   logic timeout_evt;
   assign timeout_evt = (state_q == S_GRANT) && !own_ctl && to_hit;

   // completed-frame count per requester and start-timeout revoke count, wrapping at 0xFFFF
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt   <= '0;
         timeout_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++)
            if (frame_done && owner_q == IW'(i))
               frame_cnt[16*i +: 16] <= frame_cnt[16*i +: 16] + 16'd1;
         if (timeout_evt) timeout_cnt <= timeout_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed + randomized bench for eth_tx_arbiter with a
// rule-level selection model (priority class first, then round-robin order).
module tb_eth_tx_arbiter;
   import eth_tx_arbiter_pkg::*;

   localparam int N_REQ    = 4;
   localparam int IFG_CYC  = 12;
   localparam int START_TO = 64;
   localparam logic [3:0] HP = 4'((1 << REQ_ARP) | (1 << REQ_ICMP));

   logic       clk;
   logic       rst_n;
   logic [3:0] enable_mask;
   logic       gmii_eth_txctl;
   logic [7:0] gmii_eth_txd;
   logic       busy;
   logic [1:0] owner;
`ifdef ETH_TX_ARB_STATS_EN
   logic [63:0] frame_cnt;
   logic [15:0] timeout_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int rr_m;
   int frames_m [4];
   int timeouts_m;

   eth_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

   eth_tx_arbiter #(.N_REQ(N_REQ), .IFG_CYC(IFG_CYC), .START_TO(START_TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable_mask    (enable_mask),
      .src            (bus),
      .gmii_eth_txctl (gmii_eth_txctl),
      .gmii_eth_txd   (gmii_eth_txd),
      .busy           (busy),
      .owner          (owner)
`ifdef ETH_TX_ARB_STATS_EN
      ,
      .frame_cnt      (frame_cnt),
      .timeout_cnt    (timeout_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] onehot(input int i);
      return (i < 0) ? 32'd0 : (32'd1 << i);
   endfunction

   // high-priority class: lowest index; otherwise scan from rr position with wrap
   function automatic int model_pick(input logic [3:0] elig, input int rr);
      int cand [$];
      for (int i = 0; i < N_REQ; i++)
         if (elig[i] && HP[i]) cand.push_back(i);
      if (cand.size() > 0) return cand[0];
      for (int k = 0; k < N_REQ; k++)
         if (elig[(rr + k) % N_REQ] && !HP[(rr + k) % N_REQ]) cand.push_back((rr + k) % N_REQ);
      if (cand.size() > 0) return cand[0];
      return -1;
   endfunction

   task automatic expect_grant(input string tag, input int gap_exp, output int idx);
      int exp_idx, cyc, leak;
      exp_idx = model_pick(bus.req & enable_mask, rr_m);
      cyc = 0;
      leak = 0;
      while (bus.gnt == 4'b0000 && cyc < 300) begin
         tick();
         cyc++;
         if (gmii_eth_txctl !== 1'b0) leak++;
      end
      check({tag, "_gnt"}, 32'(bus.gnt), onehot(exp_idx));
      check({tag, "_owner"}, 32'(owner), 32'(exp_idx));
      check({tag, "_gap"}, 32'(cyc), 32'(gap_exp));
      check({tag, "_quiet"}, 32'(leak), 32'd0);
      idx  = exp_idx;
      rr_m = (exp_idx + 1) % N_REQ;
   endtask

   task automatic send_frame(input string tag, input int idx, input int len, input int stray,
                             input int mid_at, input logic [3:0] mid_req);
      int bad;
      logic [7:0] b;
      bad = 0;
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom);
         bus.tx_ctl_in[idx] = 1'b1;
         bus.tx_d_in[idx*8 +: 8] = b;
         if (stray >= 0) begin
            bus.tx_ctl_in[stray] = 1'b1;
            bus.tx_d_in[stray*8 +: 8] = ~b;
         end
         if (k == mid_at) bus.req = mid_req;
         tick();
         if (gmii_eth_txctl !== 1'b1 || gmii_eth_txd !== b || bus.gnt !== 4'(onehot(idx))) bad++;
      end
      bus.tx_ctl_in[idx] = 1'b0;
      tick();
      check({tag, "_bytes"}, 32'(bad), 32'd0);
      check({tag, "_end_txctl"}, 32'(gmii_eth_txctl), 32'd0);
      check({tag, "_end_gnt"}, 32'(bus.gnt), 32'd0);
      check({tag, "_ifg_busy"}, 32'(busy), 32'd1);
      frames_m[idx]++;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int idx, hold, nz;
      logic [3:0] r, e;

      rst_n = 1'b0;
      enable_mask = 4'hF;
      bus.req = '0;
      bus.tx_ctl_in = '0;
      bus.tx_d_in = '0;
      rr_m = 0;
      timeouts_m = 0;
      foreach (frames_m[i]) frames_m[i] = 0;
      repeat (3) tick();

      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_txctl", 32'(gmii_eth_txctl), 32'd0);
      check("rst_txd", 32'(gmii_eth_txd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_owner", 32'(owner), 32'd0);
      rst_n = 1'b1;
      tick();

      // single requester, 64-byte frame; request held so the re-grant shows the gap
      bus.req = 4'(1 << REQ_UDP1);
      expect_grant("t1", 1, idx);
      send_frame("t1", idx, 64, -1, -1, 4'b0);
      expect_grant("t1_regrant", IFG_CYC + 1, idx);
      bus.req = '0;
      tick();
      check("t1_revoke_gnt", 32'(bus.gnt), 32'd0);
      check("t1_revoke_busy", 32'(busy), 32'd0);

      // two round-robin sources held for six frames
      bus.req = 4'((1 << REQ_UDP1) | (1 << REQ_UDP2));
      expect_grant("t2_0", 1, idx);
      send_frame("t2_0", idx, $urandom_range(8, 48), -1, -1, 4'b0);
      for (int f = 1; f < 6; f++) begin
         expect_grant("t2_n", IFG_CYC + 1, idx);
         send_frame("t2_n", idx, $urandom_range(8, 48), -1, -1, 4'b0);
      end
      bus.req = '0;
      drain("t2");

      // ARP request arrives mid-frame of source 3; it goes next, ahead of source 2
      bus.req = 4'(1 << REQ_UDP2);
      expect_grant("t3_udp2", 1, idx);
      send_frame("t3_udp2", idx, 30, -1, 10, 4'b1101);
      expect_grant("t3_arp", IFG_CYC + 1, idx);
      send_frame("t3_arp", idx, 16, -1, 0, 4'b1100);
      expect_grant("t3_after", IFG_CYC + 1, idx);
      bus.req = '0;
      drain("t3");

      // start timeout: grant held START_TO cycles, then IDLE with no gap
      bus.req = 4'(1 << REQ_ICMP);
      expect_grant("t4", 1, idx);
      hold = 0;
      while (bus.gnt == 4'b0010 && hold < 200) begin
         hold++;
         tick();
      end
      timeouts_m++;
      check("t4_hold", 32'(hold), 32'(START_TO));
      check("t4_busy", 32'(busy), 32'd0);
      check("t4_txctl", 32'(gmii_eth_txctl), 32'd0);
      expect_grant("t4_regrant", 1, idx);
`ifdef ETH_TX_ARB_STATS_EN
      check("t4_timeout_cnt", 32'(timeout_cnt), 32'(timeouts_m));
`endif
      bus.req = '0;
      drain("t4");

      // disabled requester never granted; stray txctl from a non-owner never reaches gmii
      enable_mask = 4'b0111;
      bus.req = 4'(1 << REQ_UDP2);
      nz = 0;
      repeat (20) begin
         tick();
         if (bus.gnt !== 4'b0000 || busy !== 1'b0) nz++;
      end
      check("t5_masked", 32'(nz), 32'd0);
      bus.req = 4'b1100;
      expect_grant("t5", 1, idx);
      send_frame("t5", idx, 40, REQ_UDP2, 5, 4'b1000);
      nz = 0;
      repeat (20) begin
         tick();
         if (gmii_eth_txctl !== 1'b0 || bus.gnt !== 4'b0000) nz++;
      end
      check("t5_stray_idle", 32'(nz), 32'd0);
      bus.tx_ctl_in = '0;
      enable_mask = 4'hF;
      bus.req = '0;
      drain("t5");

      // reset at byte 20 of a frame, then clean re-grant
      bus.req = 4'(1 << REQ_UDP1);
      expect_grant("t6", 1, idx);
      nz = 0;
      for (int k = 0; k < 20; k++) begin
         bus.tx_ctl_in[idx] = 1'b1;
         bus.tx_d_in[idx*8 +: 8] = 8'(k + 1);
         tick();
         if (gmii_eth_txctl !== 1'b1 || gmii_eth_txd !== 8'(k + 1)) nz++;
      end
      check("t6_pre_bytes", 32'(nz), 32'd0);
      bus.tx_d_in[idx*8 +: 8] = 8'd21;
      rst_n = 1'b0;
      #1;
      check("t6_rst_txctl", 32'(gmii_eth_txctl), 32'd0);
      check("t6_rst_gnt", 32'(bus.gnt), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_owner", 32'(owner), 32'd0);
      tick();
      bus.tx_ctl_in = '0;
      tick();
      rr_m = 0;
      timeouts_m = 0;
      foreach (frames_m[i]) frames_m[i] = 0;
      rst_n = 1'b1;
      expect_grant("t6_regrant", 1, idx);
      send_frame("t6_frame", idx, 24, -1, -1, 4'b0);
      bus.req = '0;
      drain("t6");

      // randomized request/enable patterns checked against the selection model
      for (int it = 0; it < 10; it++) begin
         r = 4'($urandom_range(1, 15));
         e = 4'($urandom_range(0, 15));
         if ((r & e) == 4'b0000) e = 4'hF;
         enable_mask = e;
         bus.req = r;
         expect_grant("t7", 1, idx);
         send_frame("t7", idx, $urandom_range(4, 20), -1, -1, 4'b0);
         bus.req = '0;
         drain("t7");
      end
      enable_mask = 4'hF;

`ifdef ETH_TX_ARB_STATS_EN
      for (int i = 0; i < N_REQ; i++)
         check("stats_frame_cnt", 32'(frame_cnt[16*i +: 16]), 32'(frames_m[i]));
      check("stats_timeout_cnt", 32'(timeout_cnt), 32'(timeouts_m));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
